axi_write_sched: RTL

Write-request scheduler placed in front of the AXI-Lite single-write engine. It arbitrates up to NREQ requesters (requester 0 optionally strict-priority, others round-robin) and buffers accepted commands in a small FIFO. It then issues them one at a time over the engine's req/ack port and returns per-requester completion or timeout status.

---
 rtl/axi_write_sched_pkg.sv | 16 +
 rtl/adam_seq_if.sv | 8 +
 rtl/axi_write_sched_cmd_fifo.sv | 49 ++++
 rtl/axi_write_sched.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/axi_write_sched_pkg.sv
// Shared types for the write-request scheduler: issue FSM states and the
// buffered command record.
package axi_write_sched_pkg;

  // id is sized for the largest supported requester count (8)
  localparam int ID_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} sched_state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic [31:0]     data;
  } cmd_t;

endpackage

// File: rtl/adam_seq_if.sv
// Clock/reset bundle shared by sequential blocks; reset is async active-high.
interface ADAM_SEQ;
  logic clk;
  logic rst;

  modport Master (output clk, output rst);
  modport Slave  (input clk, input rst);
endinterface

// File: rtl/axi_write_sched_cmd_fifo.sv
// DEPTH-entry synchronous command FIFO; head entry stays visible until popped.
module sched_cmd_fifo
  import axi_write_sched_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  cmd_t          din_i,
  input  logic          pop_i,
  output cmd_t          dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign level_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // DEPTH is a power of two, so pointers wrap on their own
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/axi_write_sched.sv
// Arbitrates NREQ write requesters into a command FIFO and issues the head
// command to the single-write engine, reporting done or timeout per requester.
module axi_write_sched
  import axi_write_sched_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int DEPTH   = 4,
  parameter  int TIMEOUT = 255,
  parameter  int PRIO0   = 1,
  localparam int IW      = $clog2(NREQ),
  localparam int LW      = $clog2(DEPTH + 1)
) (
  ADAM_SEQ.Slave                 seq_port,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0][31:0]  addr_i,
  input  logic [NREQ-1:0][31:0]  data_i,
  output logic [NREQ-1:0]        grant_o,
  output logic [NREQ-1:0]        done_o,
  output logic [NREQ-1:0]        err_o,
  output logic [31:0]            wr_addr_o,
  output logic [31:0]            wr_data_o,
  output logic                   wr_req_o,
  input  logic                   wr_ack_i,
  output logic                   busy_o,
  output logic [LW-1:0]          level_o
);

  sched_state_e    state_q, state_d;
  logic [15:0]     timer_q, timer_d;
  logic [IW-1:0]   rr_q, rr_d, id_q, id_d, gnt_idx, cand;
  logic            wr_req_q, wr_req_d, gnt_vld, pop;
  logic [31:0]     addr_q, addr_d, data_q, data_d;
  logic [NREQ-1:0] done_q, done_d, err_q, err_d;
  logic            fifo_full, fifo_empty;
  cmd_t            push_cmd, head;

  // Arbiter: grant only while there is room; no bypass around the FIFO
  always_comb begin
    grant_o = '0;
    gnt_vld = 1'b0;
    gnt_idx = rr_q;
    cand    = rr_q;
    if (!fifo_full) begin
      if (PRIO0 != 0 && req_i[0]) begin
        gnt_vld = 1'b1;
        gnt_idx = '0;
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          cand = IW'((int'(rr_q) + k) % NREQ);
          if (!gnt_vld && req_i[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
          end
        end
      end
      if (gnt_vld) grant_o[gnt_idx] = 1'b1;
    end
  end

  assign rr_d          = gnt_vld ? gnt_idx : rr_q;
  assign push_cmd.id   = ID_W'(gnt_idx);
  assign push_cmd.addr = addr_i[gnt_idx];
  assign push_cmd.data = data_i[gnt_idx];

  sched_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (seq_port.clk),
    .rst_i   (seq_port.rst),
    .push_i  (gnt_vld),
    .din_i   (push_cmd),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  // Head stays in the FIFO while in flight; it is popped on ack or abort
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    wr_req_d = wr_req_q;
    addr_d   = addr_q;
    data_d   = data_q;
    id_d     = id_q;
    done_d   = '0;
    err_d    = '0;
    pop      = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        addr_d   = head.addr;
        data_d   = head.data;
        id_d     = IW'(head.id);
        wr_req_d = 1'b1;
        timer_d  = '0;
        state_d  = ISSUE;
      end
      ISSUE: if (wr_ack_i) begin
        wr_req_d     = 1'b0;
        pop          = 1'b1;
        done_d[id_q] = 1'b1;
        state_d      = GAP;
      end else if (timer_q == 16'(TIMEOUT - 1)) begin
        wr_req_d    = 1'b0;
        pop         = 1'b1;
        err_d[id_q] = 1'b1;
        state_d     = GAP;
      end else begin
        timer_d = timer_q + 16'd1;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge seq_port.clk or posedge seq_port.rst) begin
    if (seq_port.rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      rr_q     <= IW'(NREQ - 1);
      wr_req_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      id_q     <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      rr_q     <= rr_d;
      wr_req_q <= wr_req_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      id_q     <= id_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign wr_req_o  = wr_req_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign busy_o    = !fifo_empty || (state_q != IDLE);

endmodule
